// File: rtl/adc_sequencer_if.sv
// Command, response and averaged-result signals between the ADC sequencer and its neighbours.
// The sequencer uses the master modport; the ADC core / DSP side uses the slave modport.
interface adc_sequencer_if;
    logic        enable;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        response_startofpacket;
    logic        response_endofpacket;
    logic        sample_valid;
    logic [3:0]  sample_index;
    logic [4:0]  sample_channel;
    logic [11:0] sample_data;
    logic        error;

    modport master (
        input  enable, command_ready,
        input  response_valid, response_channel, response_data,
        input  response_startofpacket, response_endofpacket,
        output command_valid, command_channel, command_startofpacket, command_endofpacket,
        output sample_valid, sample_index, sample_channel, sample_data, error
    );

    modport slave (
        output enable, command_ready,
        output response_valid, response_channel, response_data,
        output response_startofpacket, response_endofpacket,
        input  command_valid, command_channel, command_startofpacket, command_endofpacket,
        input  sample_valid, sample_index, sample_channel, sample_data, error
    );
endinterface

// File: rtl/adc_sequencer.sv
// Round-robin single-sample command issuer for the modular ADC, averaging 2^AVG_LOG2
// matching responses per list entry and emitting one result strobe per entry.
module adc_sequencer #(
    parameter int                  NUM_CH   = 2,
    parameter logic [5*NUM_CH-1:0] CH_LIST  = {5'd2, 5'd1},
    parameter int                  AVG_LOG2 = 2,
    parameter int                  TIMEOUT  = 1023
) (
    input logic             clock_clk,
    input logic             reset_sink_reset,
    adc_sequencer_if.master bus
);
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1 << AVG_LOG2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]       LAST_IDX = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    // Full 16-entry table so the 4-bit list index addresses it without range issues.
    logic [4:0] ch_table [16];
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_ch_table
            if (gi < NUM_CH) begin : g_used
                assign ch_table[gi] = CH_LIST[5*gi +: 5];
            end else begin : g_unused
                assign ch_table[gi] = 5'd0;
            end
        end
    endgenerate

    state_t           state_reg;
    logic [3:0]       index_reg;
    logic [CNT_W-1:0] count_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [TMR_W-1:0] timer_reg;
    logic             cmd_valid_reg;
    logic [4:0]       cmd_channel_reg;
    logic             sample_valid_reg;
    logic [3:0]       sample_index_reg;
    logic [4:0]       sample_channel_reg;
    logic [11:0]      sample_data_reg;
    logic             error_reg;

    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] count_inc;
    logic [3:0]       index_inc;
    logic             ch_match;
    logic             avg_done;
    logic             timer_done;
    logic             wait_done;
    logic [4:0]       reissue_ch;
    logic             unused_resp_pkt;

    assign acc_sum    = acc_reg + ACC_W'(bus.response_data);
    assign count_inc  = count_reg + CNT_W'(1);
    assign index_inc  = (index_reg == LAST_IDX) ? 4'd0 : index_reg + 4'd1;
    assign ch_match   = (bus.response_channel == ch_table[index_reg]);
    assign avg_done   = (count_inc == FULL_CNT);
    assign timer_done = (timer_reg == TMR_LAST);
    // A response in the expiry cycle is still accepted; the timeout only fires without one.
    assign wait_done  = bus.response_valid || timer_done;
    assign reissue_ch = (bus.response_valid && ch_match && avg_done) ? ch_table[index_inc]
                                                                     : ch_table[index_reg];
    assign unused_resp_pkt = bus.response_startofpacket ^ bus.response_endofpacket;

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            state_reg          <= IDLE;
            index_reg          <= '0;
            count_reg          <= '0;
            acc_reg            <= '0;
            timer_reg          <= '0;
            cmd_valid_reg      <= 1'b0;
            cmd_channel_reg    <= '0;
            sample_valid_reg   <= 1'b0;
            sample_index_reg   <= '0;
            sample_channel_reg <= '0;
            sample_data_reg    <= '0;
            error_reg          <= 1'b0;
        end else begin
            sample_valid_reg <= 1'b0;
            error_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    index_reg <= '0;
                    count_reg <= '0;
                    acc_reg   <= '0;
                    timer_reg <= '0;
                    if (bus.enable) begin
                        state_reg       <= ISSUE;
                        cmd_valid_reg   <= 1'b1;
                        cmd_channel_reg <= ch_table[0];
                    end
                end
                ISSUE: begin
                    if (bus.command_ready) begin
                        state_reg     <= WAIT;
                        cmd_valid_reg <= 1'b0;
                        timer_reg     <= '0;
                    end
                end
                WAIT: begin
                    if (bus.response_valid) begin
                        if (!ch_match) begin
                            error_reg <= 1'b1;
                        end else if (avg_done) begin
                            sample_valid_reg   <= 1'b1;
                            sample_index_reg   <= index_reg;
                            sample_channel_reg <= ch_table[index_reg];
                            sample_data_reg    <= acc_sum[AVG_LOG2 +: 12];
                            acc_reg            <= '0;
                            count_reg          <= '0;
                            index_reg          <= index_inc;
                        end else begin
                            acc_reg   <= acc_sum;
                            count_reg <= count_inc;
                        end
                    end else if (timer_done) begin
                        error_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                    // With enable low the current transaction completes, then IDLE clears state.
                    if (wait_done) begin
                        if (bus.enable) begin
                            state_reg       <= ISSUE;
                            cmd_valid_reg   <= 1'b1;
                            cmd_channel_reg <= reissue_ch;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.command_valid         = cmd_valid_reg;
    assign bus.command_channel       = cmd_channel_reg;
    assign bus.command_startofpacket = cmd_valid_reg;
    assign bus.command_endofpacket   = cmd_valid_reg;
    assign bus.sample_valid          = sample_valid_reg;
    assign bus.sample_index          = sample_index_reg;
    assign bus.sample_channel        = sample_channel_reg;
    assign bus.sample_data           = sample_data_reg;
    assign bus.error                 = error_reg;
endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: default-parameter instance driven from a vector table plus
// hand sequences (ready stall, timeout, enable drop, reset), and an AVG_LOG2=0 / 3-entry instance.
module tb_adc_sequencer;
    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    adc_sequencer_if bus_a ();
    adc_sequencer_if bus_b ();

    adc_sequencer dut_a (
        .clock_clk        (clk),
        .reset_sink_reset (srst),
        .bus              (bus_a)
    );

    adc_sequencer #(
        .NUM_CH   (3),
        .CH_LIST  ({5'd6, 5'd4, 5'd3}),
        .AVG_LOG2 (0),
        .TIMEOUT  (1023)
    ) dut_b (
        .clock_clk        (clk),
        .reset_sink_reset (srst),
        .bus              (bus_b)
    );

    typedef struct {
        int cmd_ch;
        int resp_ch;
        int resp_data;
        int lat;
        int exp_err;
        int exp_sv;
        int exp_sidx;
        int exp_sch;
        int exp_sdata;
    } vec_t;

    vec_t tbl [20];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(int cmd_ch, int resp_ch, int resp_data, int lat,
                                int exp_err, int exp_sv, int exp_sidx, int exp_sch, int exp_sdata);
        vec_t v;
        v.cmd_ch    = cmd_ch;
        v.resp_ch   = resp_ch;
        v.resp_data = resp_data;
        v.lat       = lat;
        v.exp_err   = exp_err;
        v.exp_sv    = exp_sv;
        v.exp_sidx  = exp_sidx;
        v.exp_sch   = exp_sch;
        v.exp_sdata = exp_sdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd();
        int n;
        n = 0;
        while (bus_a.command_valid !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("cmd_wait", 32'(bus_a.command_valid), 1);
    endtask

    task automatic respond_a(input int ch, input int data);
        bus_a.response_valid   = 1'b1;
        bus_a.response_channel = 5'(ch);
        bus_a.response_data    = 12'(data);
        tick();
        bus_a.response_valid   = 1'b0;
    endtask

    // One command/response transaction on dut_a with command_ready and enable held high.
    task automatic do_txn(input int id);
        vec_t v;
        v = tbl[id];
        wait_cmd();
        chk("cmd_channel", 32'(bus_a.command_channel), v.cmd_ch);
        chk("cmd_sop_eop", 32'({bus_a.command_startofpacket, bus_a.command_endofpacket}), 3);
        tick();
        chk("cmd_accept", 32'(bus_a.command_valid), 0);
        chk("pulse_clear", 32'({bus_a.sample_valid, bus_a.error}), 0);
        for (int i = 1; i < v.lat; i++) tick();
        respond_a(v.resp_ch, v.resp_data);
        chk("error", 32'(bus_a.error), v.exp_err);
        chk("sample_valid", 32'(bus_a.sample_valid), v.exp_sv);
        chk("sample_index", 32'(bus_a.sample_index), v.exp_sidx);
        chk("sample_channel", 32'(bus_a.sample_channel), v.exp_sch);
        chk("sample_data", 32'(bus_a.sample_data), v.exp_sdata);
        chk("next_cmd_latency", 32'(bus_a.command_valid), 1);
        $display("txn %0d: cmd ch %0d, resp ch %0d data %0d lat %0d -> error %0b sample_valid %0b idx %0d ch %0d data %0d",
                 id, v.cmd_ch, v.resp_ch, v.resp_data, v.lat, bus_a.error, bus_a.sample_valid,
                 bus_a.sample_index, bus_a.sample_channel, bus_a.sample_data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int exp_b_ch [4];
        int exp_b_idx [4];

        tbl[0]  = mk(1, 1, 100,  3, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 5, 4000, 3, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 102,  1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 104,  3, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1, 106,  3, 0, 1, 0, 1, 103);
        tbl[5]  = mk(2, 2, 4095, 5, 0, 0, 0, 1, 103);
        tbl[6]  = mk(2, 2, 4095, 3, 0, 0, 0, 1, 103);
        tbl[7]  = mk(2, 2, 4095, 2, 0, 0, 0, 1, 103);
        tbl[8]  = mk(2, 2, 1,    3, 0, 1, 1, 2, 3071);
        tbl[9]  = mk(1, 1, 24,   3, 0, 0, 1, 2, 3071);
        tbl[10] = mk(1, 1, 32,   3, 0, 1, 0, 1, 20);
        tbl[11] = mk(2, 2, 40,   3, 0, 0, 0, 1, 20);
        tbl[12] = mk(1, 1, 1,    3, 0, 0, 0, 1, 20);
        tbl[13] = mk(1, 1, 2,    3, 0, 0, 0, 1, 20);
        tbl[14] = mk(1, 1, 3,    3, 0, 0, 0, 1, 20);
        tbl[15] = mk(1, 1, 6,    3, 0, 1, 0, 1, 3);
        tbl[16] = mk(1, 1, 10,   3, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 1, 10,   3, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 1, 10,   3, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 1, 10,   3, 0, 1, 0, 1, 10);
        exp_b_ch[0] = 3; exp_b_ch[1] = 4; exp_b_ch[2] = 6; exp_b_ch[3] = 3;
        exp_b_idx[0] = 0; exp_b_idx[1] = 1; exp_b_idx[2] = 2; exp_b_idx[3] = 0;

        srst = 1'b1;
        bus_a.enable = 1'b0;  bus_a.command_ready = 1'b1;
        bus_a.response_valid = 1'b0; bus_a.response_channel = '0; bus_a.response_data = '0;
        bus_a.response_startofpacket = 1'b0; bus_a.response_endofpacket = 1'b0;
        bus_b.enable = 1'b0;  bus_b.command_ready = 1'b1;
        bus_b.response_valid = 1'b0; bus_b.response_channel = '0; bus_b.response_data = '0;
        bus_b.response_startofpacket = 1'b0; bus_b.response_endofpacket = 1'b0;

        repeat (3) tick();
        chk("reset_outputs_a", 32'({bus_a.command_valid, bus_a.command_channel, bus_a.command_startofpacket,
                                    bus_a.command_endofpacket, bus_a.sample_valid, bus_a.sample_index,
                                    bus_a.sample_channel, bus_a.sample_data, bus_a.error}), 0);
        chk("reset_outputs_b", 32'({bus_b.command_valid, bus_b.command_channel, bus_b.sample_valid,
                                    bus_b.sample_data, bus_b.error}), 0);
        srst = 1'b0;
        repeat (3) tick();
        chk("idle_while_disabled", 32'(bus_a.command_valid), 0);
        bus_a.enable = 1'b1;

        for (int i = 0; i <= 8; i++) do_txn(i);

        // command_ready stalled for 20 cycles: command must hold, then be accepted exactly once
        bus_a.command_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_a.command_valid === 1'b1 && bus_a.command_channel === 5'd1 &&
                bus_a.command_startofpacket === 1'b1 && bus_a.command_endofpacket === 1'b1) n++;
        end
        chk("ready_low_stable_cycles", n, 20);
        bus_a.command_ready = 1'b1;
        tick();
        chk("ready_low_accept", 32'(bus_a.command_valid), 0);
        n = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus_a.command_valid !== 1'b0) n++;
        end
        chk("single_accept", n, 0);
        respond_a(1, 8);
        chk("stall_resp_error", 32'(bus_a.error), 0);
        chk("stall_resp_next_cmd", 32'(bus_a.command_valid), 1);
        $display("stall: 20 cycles ready low, resp ch 1 data 8 -> error %0b sample_valid %0b",
                 bus_a.error, bus_a.sample_valid);

        // lost response: error after TIMEOUT WAIT cycles, same entry reissued, average kept
        wait_cmd();
        chk("to_cmd_channel", 32'(bus_a.command_channel), 1);
        tick();
        chk("to_accept", 32'(bus_a.command_valid), 0);
        n = 0;
        while (bus_a.error !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 1023);
        chk("to_reissue", 32'({bus_a.command_valid, bus_a.command_channel}), 33);
        chk("to_no_sample", 32'(bus_a.sample_valid), 0);
        $display("timeout: error after %0d WAIT cycles, reissue ch %0d", n, bus_a.command_channel);
        tick();
        chk("error_pulse_width", 32'(bus_a.error), 0);
        chk("reissue_accept", 32'(bus_a.command_valid), 0);
        for (int i = 1; i < 1023; i++) tick();
        respond_a(1, 16);
        chk("resp_beats_timeout", 32'(bus_a.error), 0);
        chk("resp_beats_next_cmd", 32'(bus_a.command_valid), 1);
        $display("expiry-cycle resp ch 1 data 16 -> error %0b", bus_a.error);

        for (int i = 9; i <= 11; i++) do_txn(i);

        // enable dropped while in ISSUE: finish handshake and response, then sit in IDLE
        bus_a.command_ready = 1'b0;
        bus_a.enable = 1'b0;
        tick();
        chk("dis_hold_valid", 32'(bus_a.command_valid), 1);
        bus_a.command_ready = 1'b1;
        tick();
        chk("dis_accept", 32'(bus_a.command_valid), 0);
        tick();
        tick();
        respond_a(2, 40);
        chk("dis_to_idle", 32'(bus_a.command_valid), 0);
        chk("dis_no_sample", 32'(bus_a.sample_valid), 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_a.command_valid !== 1'b0 || bus_a.sample_valid !== 1'b0) n++;
        end
        chk("dis_idle_quiet", n, 0);
        $display("disable: resp ch 2 data 40 completed, idle with no result");
        bus_a.enable = 1'b1;

        for (int i = 12; i <= 15; i++) do_txn(i);

        // reset while a command is pending
        bus_a.command_ready = 1'b0;
        tick();
        tick();
        chk("pre_reset_valid", 32'(bus_a.command_valid), 1);
        srst = 1'b1;
        tick();
        chk("mid_reset_outputs", 32'({bus_a.command_valid, bus_a.command_channel, bus_a.command_startofpacket,
                                      bus_a.command_endofpacket, bus_a.sample_valid, bus_a.sample_index,
                                      bus_a.sample_channel, bus_a.sample_data, bus_a.error}), 0);
        $display("reset: outputs cleared while command pending");
        tick();
        srst = 1'b0;
        bus_a.command_ready = 1'b1;

        for (int i = 16; i <= 19; i++) do_txn(i);

        // single-sample averaging over a 3-entry list: wrap back to entry 0
        bus_b.enable = 1'b1;
        for (int r = 0; r < 4; r++) begin
            n = 0;
            while (bus_b.command_valid !== 1'b1 && n < 64) begin
                tick();
                n++;
            end
            chk("b_cmd_wait", 32'(bus_b.command_valid), 1);
            chk("b_cmd_channel", 32'(bus_b.command_channel), exp_b_ch[r]);
            tick();
            chk("b_cmd_accept", 32'(bus_b.command_valid), 0);
            bus_b.response_valid   = 1'b1;
            bus_b.response_channel = 5'(exp_b_ch[r]);
            bus_b.response_data    = 12'd4095;
            tick();
            bus_b.response_valid   = 1'b0;
            chk("b_sample_valid", 32'(bus_b.sample_valid), 1);
            chk("b_sample_index", 32'(bus_b.sample_index), exp_b_idx[r]);
            chk("b_sample_channel", 32'(bus_b.sample_channel), exp_b_ch[r]);
            chk("b_sample_data", 32'(bus_b.sample_data), 4095);
            chk("b_error", 32'(bus_b.error), 0);
            chk("b_next_cmd", 32'(bus_b.command_valid), 1);
            $display("b txn %0d: resp ch %0d data 4095 -> sample_valid %0b idx %0d ch %0d data %0d",
                     r, exp_b_ch[r], bus_b.sample_valid, bus_b.sample_index,
                     bus_b.sample_channel, bus_b.sample_data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
